// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: parametrised pipeline register bank with valid bits, stall, flush and stall counter
module pipe_reg_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int CNT_W = 16,
  localparam int OCC_W = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic clr,
  input  logic stall,
  input  logic flush,
  input  logic in_valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic q_valid,
  output logic [DEPTH-1:0] stage_valid,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [WIDTH-1:0] stg [DEPTH];
  logic [WIDTH-1:0] shift_d [DEPTH];
  logic [DEPTH-1:0] vld, shift_v;
  logic [OCC_W-1:0] occ_nxt;
  genvar s;
  generate
    for (s = 0; s < DEPTH; s++) begin : g_stage
      if (s == 0) begin : g_head
        assign shift_d[0] = in_valid ? d : BUBBLE;
        assign shift_v[0] = in_valid;
      end else begin : g_body
        assign shift_d[s] = stg[s-1];
        assign shift_v[s] = vld[s-1];
      end
    end
  endgenerate
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(shift_v[i]);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      stg <= '{default: RESET_VAL};
      vld <= '0;
      occupancy <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      stg <= '{default: BUBBLE};
      vld <= '0;
      occupancy <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + CNT_W'(~&stall_cnt);
    end else begin
      stg <= shift_d;
      vld <= shift_v;
      occupancy <= occ_nxt;
    end
  end
  assign q = stg[DEPTH-1];
  assign q_valid = vld[DEPTH-1];
  assign stage_valid = vld;
endmodule
